// File: rtl/aes_ctr_pkg.sv
// rtl/aes_ctr_pkg.sv - shared types, constants and AES/CTR helper functions
package aes_ctr_pkg;

    localparam int AES_BLK_W = 128;
    localparam int AES_KEY_W = 256;

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    // Byte i of a block is [127-8i -: 8]; only the leading bytes survive.
    function automatic logic [127:0] tail_mask(input logic [4:0] last_bytes);
        logic [127:0] m;
        int n;
        n = (last_bytes == 5'd0 || last_bytes > 5'd16) ? 16 : int'(last_bytes);
        m = '0;
        for (int i = 0; i < 16; i++) begin
            if (i < n) m[127-8*i -: 8] = 8'hff;
        end
        return m;
    endfunction

    function automatic logic [127:0] ctr_mask(input int width);
        return (width >= 128) ? {128{1'b1}} : ((128'd1 << width) - 128'd1);
    endfunction

    function automatic logic [127:0] ctr_inc(input logic [127:0] ctr, input int width);
        logic [127:0] mask;
        mask = ctr_mask(width);
        return (ctr & ~mask) | ((ctr + 128'd1) & mask);
    endfunction

    function automatic logic [7:0] xtime(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] x;
        p = 8'h00;
        x = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ x;
            x = xtime(x);
        end
        return p;
    endfunction

    // Inverse as x^254 (product of x^2..x^128), then the AES affine map.
    function automatic logic [7:0] sbox(input logic [7:0] x);
        logic [7:0] t;
        logic [7:0] inv;
        t   = x;
        inv = 8'h01;
        for (int k = 1; k < 8; k++) begin
            t   = gf_mul(t, t);
            inv = gf_mul(inv, t);
        end
        return inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]} ^
               {inv[4:0], inv[7:5]} ^ {inv[3:0], inv[7:4]} ^ 8'h63;
    endfunction

    function automatic logic [127:0] sub_shift(input logic [127:0] s);
        logic [127:0] o;
        o = '0;
        for (int c = 0; c < 4; c++) begin
            for (int r = 0; r < 4; r++) begin
                o[127-8*(4*c+r) -: 8] = sbox(s[127-8*(4*((c+r)%4)+r) -: 8]);
            end
        end
        return o;
    endfunction

    function automatic logic [127:0] mix_columns(input logic [127:0] s);
        logic [127:0] o;
        logic [7:0] a0, a1, a2, a3;
        o = '0;
        for (int c = 0; c < 4; c++) begin
            a0 = s[127-32*c -: 8];
            a1 = s[119-32*c -: 8];
            a2 = s[111-32*c -: 8];
            a3 = s[103-32*c -: 8];
            o[127-32*c -: 8] = xtime(a0) ^ xtime(a1) ^ a1 ^ a2 ^ a3;
            o[119-32*c -: 8] = a0 ^ xtime(a1) ^ xtime(a2) ^ a2 ^ a3;
            o[111-32*c -: 8] = a0 ^ a1 ^ xtime(a2) ^ xtime(a3) ^ a3;
            o[103-32*c -: 8] = xtime(a0) ^ a0 ^ a1 ^ a2 ^ xtime(a3);
        end
        return o;
    endfunction

    // AES-256 schedule: round key j from round keys j-2 (prev) and j-1 (cur).
    function automatic logic [127:0] key_step(input logic [127:0] prev, input logic [127:0] cur,
                                              input int j);
        logic [31:0] t;
        logic [31:0] n0, n1, n2, n3;
        logic [7:0]  rc;
        t = cur[31:0];
        if (j % 2 == 0) begin
            rc = 8'h01 << (j/2 - 1);
            t  = {sbox(t[23:16]), sbox(t[15:8]), sbox(t[7:0]), sbox(t[31:24])} ^ {rc, 24'h0};
        end else begin
            t  = {sbox(t[31:24]), sbox(t[23:16]), sbox(t[15:8]), sbox(t[7:0])};
        end
        n0 = prev[127:96] ^ t;
        n1 = prev[95:64]  ^ n0;
        n2 = prev[63:32]  ^ n1;
        n3 = prev[31:0]   ^ n2;
        return {n0, n1, n2, n3};
    endfunction

endpackage

// File: rtl/encryptiontop.sv
// rtl/encryptiontop.sv - iterative AES-256 core, free-running on its plaintext input
module encryptiontop
    import aes_ctr_pkg::*;
(
    input  logic                 clk,
    input  logic                 rst,
    input  logic [AES_BLK_W-1:0] plaintext,
    input  logic [AES_KEY_W-1:0] key,
    output logic [AES_BLK_W-1:0] ciphertext,
    output logic                 cipher_counter_o
);

    logic [3:0]           rnd;
    logic [AES_BLK_W-1:0] st;
    logic [AES_BLK_W-1:0] rk_cur;
    logic [AES_BLK_W-1:0] rk_prev;
    logic [AES_BLK_W-1:0] ss;
    logic [AES_BLK_W-1:0] mixed;
    logic [AES_BLK_W-1:0] rk_next;

    always_comb begin
        ss      = sub_shift(st);
        mixed   = mix_columns(ss);
        rk_next = key_step(rk_prev, rk_cur, int'(rnd) + 1);
    end

    // rnd 0 loads plaintext, 1..14 are rounds, 15 presents the result for one
    // cycle so a counter update lands before the next load.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rnd              <= 4'd0;
            st               <= '0;
            rk_cur           <= '0;
            rk_prev          <= '0;
            ciphertext       <= '0;
            cipher_counter_o <= 1'b0;
        end else begin
            case (rnd)
                4'd0: begin
                    st      <= plaintext ^ key[255:128];
                    rk_prev <= key[255:128];
                    rk_cur  <= key[127:0];
                    rnd     <= 4'd1;
                end
                4'd14: begin
                    ciphertext       <= ss ^ rk_cur;
                    cipher_counter_o <= 1'b1;
                    rnd              <= 4'd15;
                end
                4'd15: begin
                    cipher_counter_o <= 1'b0;
                    rnd              <= 4'd0;
                end
                default: begin
                    st      <= mixed ^ rk_cur;
                    rk_prev <= rk_cur;
                    rk_cur  <= rk_next;
                    rnd     <= rnd + 4'd1;
                end
            endcase
        end
    end

endmodule

// File: rtl/ks_fifo.sv
// rtl/ks_fifo.sv - synchronous keystream FIFO with full/empty flags
module ks_fifo #(
    parameter int DEPTH = 4,
    parameter int W     = 128
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         push,
    input  logic [W-1:0] push_data,
    input  logic         pop,
    output logic [W-1:0] pop_data,
    output logic         full,
    output logic         empty
);

    localparam int AW = $clog2(DEPTH);

    logic [W-1:0] mem [DEPTH];
    logic [AW:0]  wr_ptr;
    logic [AW:0]  rd_ptr;

    assign empty    = (wr_ptr == rd_ptr);
    assign full     = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign pop_data = mem[rd_ptr[AW-1:0]];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (push && !full)  wr_ptr <= wr_ptr + 1'b1;
            if (pop  && !empty) rd_ptr <= rd_ptr + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (push && !full) mem[wr_ptr[AW-1:0]] <= push_data;
    end

endmodule

// File: rtl/aes_ctr_stream.sv
// rtl/aes_ctr_stream.sv - streaming AES-256 CTR engine with keystream prefetch
module aes_ctr_stream
    import aes_ctr_pkg::*;
#(
    parameter int NB_W      = 16,
    parameter int CTR_WIDTH = 32,
    parameter int KS_DEPTH  = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic [AES_KEY_W-1:0] key,
    input  logic [AES_BLK_W-1:0] iv,
    input  logic [NB_W-1:0]      num_blocks,
    input  logic [4:0]           last_bytes,
    input  logic                 s_valid,
    output logic                 s_ready,
    input  logic [AES_BLK_W-1:0] s_data,
    output logic                 m_valid,
    input  logic                 m_ready,
    output logic [AES_BLK_W-1:0] m_data,
    output logic                 m_last,
    output logic                 busy,
    output logic                 done,
    output logic                 ctr_wrap
);

    localparam logic [AES_BLK_W-1:0] CTR_MASK = ctr_mask(CTR_WIDTH);

    state_t               state;
    state_t               state_nxt;
    logic [AES_KEY_W-1:0] key_q;
    logic [AES_BLK_W-1:0] ctr;
    logic [NB_W-1:0]      nb_q;
    logic [NB_W-1:0]      gen_cnt;
    logic [NB_W-1:0]      out_cnt;
    logic [4:0]           lb_q;
    logic                 core_rst;
    logic                 core_valid;
    logic [AES_BLK_W-1:0] core_ks;
    logic                 fifo_full;
    logic                 fifo_empty;
    logic [AES_BLK_W-1:0] fifo_head;
    logic                 push;
    logic                 s_hs;
    logic                 m_hs;
    logic                 is_last;
    logic                 job_start;

    assign core_rst  = rst | (state == IDLE);
    assign job_start = (state == IDLE) && start;
    assign push      = (state == RUN) && core_valid && !fifo_full && (gen_cnt < nb_q);
    assign s_hs      = s_valid && s_ready;
    assign m_hs      = m_valid && m_ready;
    assign is_last   = (out_cnt == nb_q - NB_W'(1));

    encryptiontop u_core (
        .clk              (clk),
        .rst              (core_rst),
        .plaintext        (ctr),
        .key              (key_q),
        .ciphertext       (core_ks),
        .cipher_counter_o (core_valid)
    );

    ks_fifo #(
        .DEPTH (KS_DEPTH),
        .W     (AES_BLK_W)
    ) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (push),
        .push_data (core_ks),
        .pop       (s_hs),
        .pop_data  (fifo_head),
        .full      (fifo_full),
        .empty     (fifo_empty)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    // An empty job spends one cycle in RUN, keeping done two cycles after start.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (start) state_nxt = RUN;
            RUN:     if (nb_q == '0 || (m_hs && m_last)) state_nxt = DONE;
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        s_ready = 1'b0;
        busy    = 1'b0;
        done    = 1'b0;
        case (state)
            RUN: begin
                busy    = 1'b1;
                s_ready = !fifo_empty && (!m_valid || m_ready);
            end
            DONE: begin
                busy = 1'b1;
                done = 1'b1;
            end
            default: ;
        endcase
    end

    // A full FIFO drops the core result and leaves ctr alone, so the same
    // counter is recomputed and no keystream is lost.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            key_q    <= '0;
            ctr      <= '0;
            nb_q     <= '0;
            lb_q     <= '0;
            gen_cnt  <= '0;
            ctr_wrap <= 1'b0;
        end else if (job_start) begin
            key_q    <= key;
            ctr      <= iv;
            nb_q     <= num_blocks;
            lb_q     <= last_bytes;
            gen_cnt  <= '0;
            ctr_wrap <= 1'b0;
        end else if (push) begin
            gen_cnt <= gen_cnt + NB_W'(1);
            ctr     <= ctr_inc(ctr, CTR_WIDTH);
            if ((ctr & CTR_MASK) == CTR_MASK) ctr_wrap <= 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            m_valid <= 1'b0;
            m_data  <= '0;
            m_last  <= 1'b0;
            out_cnt <= '0;
        end else if (job_start) begin
            out_cnt <= '0;
        end else if (s_hs) begin
            m_valid <= 1'b1;
            m_data  <= (s_data ^ fifo_head) & (is_last ? tail_mask(lb_q) : {AES_BLK_W{1'b1}});
            m_last  <= is_last;
            out_cnt <= out_cnt + NB_W'(1);
        end else if (m_ready) begin
            m_valid <= 1'b0;
            m_last  <= 1'b0;
        end
    end

endmodule

// File: tb/tb_aes_ctr_stream.sv
// tb/tb_aes_ctr_stream.sv - directed self-checking bench for aes_ctr_stream
module tb_aes_ctr_stream;

    localparam int NB_W = 16;

    localparam logic [255:0] K55 = 256'h603deb1015ca71be2b73aef0857d77811f352c073b6108d72d9810a30914dff4;
    localparam logic [127:0] IV55 = 128'hf0f1f2f3f4f5f6f7f8f9fafbfcfdfeff;
    localparam logic [127:0] PT55 [4] = '{
        128'h6bc1bee22e409f96e93d7e117393172a, 128'hae2d8a571e03ac9c9eb76fac45af8e51,
        128'h30c81c46a35ce411e5fbc1191a0a52ef, 128'hf69f2445df4f9b17ad2b417be66c3710};
    localparam logic [127:0] CT55 [4] = '{
        128'h601ec313775789a5b7a7f504bbf3d228, 128'hf443e3ca4d62b59aca84e990cacaf5c5,
        128'h2b0930daa23de94ce87017ba2d84988d, 128'hdfc9c58db67aada613c2dd08457941a6};

    logic            clk = 1'b0;
    logic            rst;
    logic            start;
    logic [255:0]    key;
    logic [127:0]    iv;
    logic [NB_W-1:0] num_blocks;
    logic [4:0]      last_bytes;
    logic            s_valid;
    logic            s_ready;
    logic [127:0]    s_data;
    logic            m_valid;
    logic            m_ready;
    logic [127:0]    m_data;
    logic            m_last;
    logic            busy;
    logic            done;
    logic            ctr_wrap;

    always #5 clk = ~clk;

    aes_ctr_stream #(.NB_W(NB_W), .CTR_WIDTH(32), .KS_DEPTH(4)) dut (
        .clk(clk), .rst(rst), .start(start), .key(key), .iv(iv),
        .num_blocks(num_blocks), .last_bytes(last_bytes),
        .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data),
        .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data), .m_last(m_last),
        .busy(busy), .done(done), .ctr_wrap(ctr_wrap)
    );

    int           checks = 0;
    int           failures = 0;
    logic [7:0]   sb [256];
    logic [127:0] pt [16];
    logic [127:0] out_data [$];
    logic         out_last [$];
    int           last_hs_cyc;
    int           done_cyc;
    int           stab_err;
    bit           timed_out;

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [7:0] xt(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [7:0] gm(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p = 8'h00;
        logic [7:0] x = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ x;
            x = xt(x);
        end
        return p;
    endfunction

    function automatic logic [127:0] aes_ref(input logic [255:0] k, input logic [127:0] p);
        logic [31:0]  w [60];
        logic [7:0]   s [16];
        logic [7:0]   t [16];
        logic [31:0]  tw;
        logic [7:0]   rc;
        logic [7:0]   a0, a1, a2, a3;
        logic [127:0] o;
        rc = 8'h01;
        for (int i = 0; i < 8; i++) w[i] = k[255-32*i -: 32];
        for (int i = 8; i < 60; i++) begin
            tw = w[i-1];
            if (i % 8 == 0) begin
                tw = {sb[tw[23:16]], sb[tw[15:8]], sb[tw[7:0]], sb[tw[31:24]]} ^ {rc, 24'h0};
                rc = xt(rc);
            end else if (i % 8 == 4) begin
                tw = {sb[tw[31:24]], sb[tw[23:16]], sb[tw[15:8]], sb[tw[7:0]]};
            end
            w[i] = w[i-8] ^ tw;
        end
        for (int j = 0; j < 16; j++) s[j] = p[127-8*j -: 8] ^ w[j/4][31-8*(j%4) -: 8];
        for (int r = 1; r <= 14; r++) begin
            for (int j = 0; j < 16; j++) t[j] = sb[s[4*(((j/4)+(j%4))%4) + (j%4)]];
            for (int c = 0; c < 4; c++) begin
                a0 = t[4*c]; a1 = t[4*c+1]; a2 = t[4*c+2]; a3 = t[4*c+3];
                if (r < 14) begin
                    s[4*c]   = xt(a0) ^ xt(a1) ^ a1 ^ a2 ^ a3;
                    s[4*c+1] = a0 ^ xt(a1) ^ xt(a2) ^ a2 ^ a3;
                    s[4*c+2] = a0 ^ a1 ^ xt(a2) ^ xt(a3) ^ a3;
                    s[4*c+3] = xt(a0) ^ a0 ^ a1 ^ a2 ^ xt(a3);
                end else begin
                    s[4*c] = a0; s[4*c+1] = a1; s[4*c+2] = a2; s[4*c+3] = a3;
                end
            end
            for (int j = 0; j < 16; j++) s[j] = s[j] ^ w[4*r + j/4][31-8*(j%4) -: 8];
        end
        for (int j = 0; j < 16; j++) o[127-8*j -: 8] = s[j];
        return o;
    endfunction

    task automatic run_job(input logic [255:0] k, input logic [127:0] v, input int nb, input int lb,
                           input int stall, input int abort_at, input bit poke);
        int           in_idx = 0;
        int           cyc = 0;
        bit           got_done = 0;
        bit           holding = 0;
        logic [127:0] held = '0;
        out_data.delete();
        out_last.delete();
        stab_err    = 0;
        last_hs_cyc = -100;
        done_cyc    = -1;
        key = k; iv = v; num_blocks = NB_W'(nb); last_bytes = 5'(lb); start = 1'b1;
        tick();
        start = 1'b0; iv = ~v; num_blocks = '0; last_bytes = 5'd3;
        while (!got_done && cyc < 4000) begin
            if (abort_at > 0 && out_data.size() == abort_at) return;
            s_valid = (in_idx < nb);
            s_data  = (in_idx < nb) ? pt[in_idx] : '0;
            m_ready = (cyc < stall) ? 1'b0 : ((stall > 0) ? 1'($urandom_range(0, 1)) : 1'b1);
            start   = poke && (cyc == 3);
            #1;
            if (holding && (!m_valid || m_data !== held)) stab_err++;
            holding = m_valid && !m_ready;
            held    = m_data;
            if (s_valid && s_ready) in_idx++;
            if (m_valid && m_ready) begin
                out_data.push_back(m_data);
                out_last.push_back(m_last);
                last_hs_cyc = cyc;
            end
            tick();
            cyc++;
            if (done) begin
                got_done = 1;
                done_cyc = cyc;
            end
        end
        start = 1'b0; s_valid = 1'b0; m_ready = 1'b0;
        timed_out = !got_done;
    endtask

    task automatic check_job(input string tag, input int nb, input logic [127:0] exp [16], input bit wrap);
        logic [127:0] d;
        logic         l;
        chk({tag, "_timeout"}, 128'(timed_out), 128'd0);
        chk({tag, "_count"}, 128'(out_data.size()), 128'(nb));
        for (int i = 0; i < nb; i++) begin
            d = 'x;
            l = 1'bx;
            if (i < out_data.size()) begin
                d = out_data[i];
                l = out_last[i];
            end
            chk($sformatf("%s_blk%0d", tag, i), d, exp[i]);
            chk($sformatf("%s_last%0d", tag, i), 128'(l), 128'(i == nb - 1));
        end
        chk({tag, "_done_lat"}, 128'(done_cyc - last_hs_cyc), 128'd1);
        chk({tag, "_stable"}, 128'(stab_err), 128'd0);
        chk({tag, "_wrap"}, 128'(ctr_wrap), 128'(wrap));
        tick();
        chk({tag, "_idle"}, 128'({busy, done}), 128'd0);
    endtask

    initial begin
        logic [127:0] exp [16];
        logic [7:0]   inv;
        logic [7:0]   c63;
        logic [7:0]   sv;
        logic [127:0] wiv;
        logic [3:0]   dseq;
        logic         any_sm;

        c63 = 8'h63;
        for (int x = 0; x < 256; x++) begin
            inv = 8'h00;
            for (int y = 1; y < 256; y++) if (gm(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
            for (int b = 0; b < 8; b++)
                sv[b] = inv[b] ^ inv[(b+4)%8] ^ inv[(b+5)%8] ^ inv[(b+6)%8] ^ inv[(b+7)%8] ^ c63[b];
            sb[x] = sv;
        end

        rst = 1'b1; start = 1'b0; key = '0; iv = '0; num_blocks = '0; last_bytes = '0;
        s_valid = 1'b0; s_data = '0; m_ready = 1'b0;
        repeat (3) tick();
        chk("reset_flags", 128'({s_ready, m_valid, m_last, busy, done, ctr_wrap}), 128'd0);
        chk("reset_mdata", m_data, 128'd0);
        rst = 1'b0;
        tick();

        for (int i = 0; i < 4; i++) begin pt[i] = PT55[i]; exp[i] = CT55[i]; end
        run_job(K55, IV55, 4, 16, 0, 0, 1);
        check_job("f55", 4, exp, 0);

        run_job(K55, IV55, 4, 16, 40, 0, 0);
        check_job("bp", 4, exp, 0);

        for (int i = 0; i < 7; i++) begin
            pt[i]  = '0;
            exp[i] = aes_ref(K55, IV55 + 128'(i));
        end
        run_job(K55, IV55, 7, 16, 200, 0, 0);
        check_job("fill", 7, exp, 0);

        pt[0]  = PT55[0];
        exp[0] = 128'h601ec313770000000000000000000000;
        run_job(K55, IV55, 1, 5, 0, 0, 0);
        check_job("tail", 1, exp, 0);

        wiv = {IV55[127:32], 32'hffffffff};
        pt[0] = '0; pt[1] = '0;
        exp[0] = aes_ref(K55, wiv);
        exp[1] = aes_ref(K55, {IV55[127:32], 32'h00000000});
        run_job(K55, wiv, 2, 16, 0, 0, 0);
        check_job("wrap", 2, exp, 1);

        key = K55; iv = IV55; num_blocks = '0; last_bytes = '0; start = 1'b1;
        tick();
        start = 1'b0;
        chk("empty_busy", 128'(busy), 128'd1);
        any_sm = 1'b0;
        for (int i = 0; i < 4; i++) begin
            dseq[i] = done;
            any_sm  = any_sm | s_ready | m_valid;
            tick();
        end
        chk("empty_done_seq", 128'(dseq), 128'(4'b0010));
        chk("empty_no_xfer", 128'(any_sm), 128'd0);

        for (int i = 0; i < 4; i++) pt[i] = PT55[i];
        run_job(K55, IV55, 4, 16, 0, 1, 0);
        s_valid = 1'b0; m_ready = 1'b0; start = 1'b0;
        chk("midrst_busy_before", 128'(busy), 128'd1);
        rst = 1'b1;
        #1;
        chk("midrst_flags", 128'({s_ready, m_valid, m_last, busy, done, ctr_wrap}), 128'd0);
        chk("midrst_mdata", m_data, 128'd0);
        tick();
        rst = 1'b0;
        tick();
        for (int i = 0; i < 4; i++) exp[i] = CT55[i];
        run_job(K55, IV55, 4, 16, 0, 0, 0);
        check_job("post_rst", 4, exp, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
